// File: rtl/matriz_leds_scan.sv
// Self-timed LED-matrix column scanner with a double-buffered frame memory and inter-column blanking.
// Optional feature macro BRIGHTNESS_EN adds a brightness input that shortens the drive phase of each slot.
module matriz_leds_scan #(
    parameter int ROWS           = 7,
    parameter int COLS           = 5,
    parameter int DIV            = 65536,
    parameter int BLANK          = 64,
    parameter int ROW_ACTIVE_LOW = 1,
    parameter int BW             = 8,
    localparam int CW            = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            enable,
    input  logic            wr_en,
    input  logic [CW-1:0]   wr_col,
    input  logic [ROWS-1:0] wr_data,
    input  logic            swap_req,
`ifdef BRIGHTNESS_EN
    input  logic [BW-1:0]   brightness,
`endif
    output logic            swap_ack,
    output logic            frame_start,
    output logic [COLS-1:0] col_out,
    output logic [ROWS-1:0] row_out
);

    localparam int SCW = $clog2(DIV);
    localparam logic [ROWS-1:0] ROW_IDLE = (ROW_ACTIVE_LOW != 0) ? {ROWS{1'b1}} : {ROWS{1'b0}};

    function automatic logic [ROWS-1:0] row_drive(input logic [ROWS-1:0] bitmap);
        if (ROW_ACTIVE_LOW != 0) begin
            row_drive = ~bitmap;
        end else begin
            row_drive = bitmap;
        end
    endfunction

    function automatic logic [COLS-1:0] col_onehot(input logic [CW-1:0] idx);
        col_onehot = COLS'(1'b1) << idx;
    endfunction

    logic [SCW-1:0]  sc_q, sc_d;
    logic [CW-1:0]   col_q, col_d;
    logic            pending_q, pending_d;
    logic            swap_ack_q, swap_ack_d;
    logic            frame_start_q, frame_start_d;
    logic [COLS-1:0] col_out_q, col_out_d;
    logic [ROWS-1:0] row_out_q, row_out_d;
    logic [ROWS-1:0] front_q [COLS];
    logic [ROWS-1:0] back_q  [COLS];

    logic            slot_end_s;
    logic            frame_end_s;
    logic            swap_do_s;
    logic            wr_ok_s;
    logic            in_drive_s;
    logic [32:0]     drive_limit_s;

    // Drive window ends at BLANK+brightness, computed wide so it can never wrap.
`ifdef BRIGHTNESS_EN
    assign drive_limit_s = 33'(BLANK) + 33'(brightness);
`else
    assign drive_limit_s = 33'(DIV);
`endif

    assign slot_end_s  = (sc_q == SCW'(DIV - 1));
    assign frame_end_s = slot_end_s && (col_q == CW'(COLS - 1));
    assign swap_do_s   = (pending_q | swap_req) & (~enable | frame_end_s);
    assign wr_ok_s     = wr_en && (32'(wr_col) < 32'(COLS));
    assign in_drive_s  = (33'(sc_q) >= 33'(BLANK)) && (33'(sc_q) < drive_limit_s);

    assign swap_ack    = swap_ack_q;
    assign frame_start = frame_start_q;
    assign col_out     = col_out_q;
    assign row_out     = row_out_q;

    // Next-state logic for the scan counters, swap bookkeeping and registered outputs.
    always_comb begin
        sc_d          = sc_q;
        col_d         = col_q;
        pending_d     = pending_q;
        swap_ack_d    = 1'b0;
        frame_start_d = 1'b0;
        col_out_d     = {COLS{1'b0}};
        row_out_d     = ROW_IDLE;

        if (!enable) begin
            sc_d  = {SCW{1'b0}};
            col_d = {CW{1'b0}};
        end else if (slot_end_s) begin
            sc_d  = {SCW{1'b0}};
            col_d = (col_q == CW'(COLS - 1)) ? {CW{1'b0}} : col_q + CW'(1);
        end else begin
            sc_d  = sc_q + SCW'(1);
        end

        pending_d     = swap_do_s ? 1'b0 : (pending_q | swap_req);
        swap_ack_d    = swap_do_s;
        frame_start_d = enable && (col_q == {CW{1'b0}}) && (sc_q == {SCW{1'b0}});

        if (enable && in_drive_s) begin
            col_out_d = col_onehot(col_q);
            row_out_d = row_drive(front_q[col_q]);
        end else begin
            col_out_d = {COLS{1'b0}};
            row_out_d = ROW_IDLE;
        end
    end

    // State and output registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sc_q          <= {SCW{1'b0}};
            col_q         <= {CW{1'b0}};
            pending_q     <= 1'b0;
            swap_ack_q    <= 1'b0;
            frame_start_q <= 1'b0;
            col_out_q     <= {COLS{1'b0}};
            row_out_q     <= ROW_IDLE;
        end else begin
            sc_q          <= sc_d;
            col_q         <= col_d;
            pending_q     <= pending_d;
            swap_ack_q    <= swap_ack_d;
            frame_start_q <= frame_start_d;
            col_out_q     <= col_out_d;
            row_out_q     <= row_out_d;
        end
    end

    // Frame buffers: front copies the pre-write back on a swap, so a same-cycle write lands only in back.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < COLS; i++) begin
                front_q[i] <= {ROWS{1'b0}};
                back_q[i]  <= {ROWS{1'b0}};
            end
        end else begin
            if (swap_do_s) begin
                for (int i = 0; i < COLS; i++) begin
                    front_q[i] <= back_q[i];
                end
            end
            if (wr_ok_s) begin
                back_q[wr_col] <= wr_data;
            end
        end
    end

endmodule

// File: tb/tb_matriz_leds_scan.sv
// Self-checking bench for matriz_leds_scan (ROWS=7, COLS=5, DIV=8, BLANK=2) with a frame-position reference model.
// Define BRIGHTNESS_EN for both files to exercise the brightness input as well.
module tb_matriz_leds_scan;

    localparam int ROWS  = 7;
    localparam int COLS  = 5;
    localparam int DIV   = 8;
    localparam int BLANK = 2;
    localparam int FRAME = COLS * DIV;

    logic            clock;
    logic            reset_n;
    logic            enable;
    logic            wr_en;
    logic [2:0]      wr_col;
    logic [ROWS-1:0] wr_data;
    logic            swap_req;
    logic [7:0]      brightness;
    logic            swap_ack;
    logic            frame_start;
    logic [COLS-1:0] col_out;
    logic [ROWS-1:0] row_out;

    int checks;
    int failures;
    int ack_seen;
    int fs_cnt;
    int act_cnt;

    // Reference model: one position counter across the whole frame plus the two buffers.
    logic [ROWS-1:0] front_m [COLS];
    logic [ROWS-1:0] back_m  [COLS];
    bit              pending_m;
    int              pos_m;

    logic [ROWS-1:0] pat [COLS];
    logic [ROWS-1:0] old3;
    logic [ROWS-1:0] new3;
    logic [ROWS-1:0] exp_rows;

    matriz_leds_scan #(
        .ROWS(ROWS), .COLS(COLS), .DIV(DIV), .BLANK(BLANK), .ROW_ACTIVE_LOW(1), .BW(8)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .enable(enable),
        .wr_en(wr_en),
        .wr_col(wr_col),
        .wr_data(wr_data),
        .swap_req(swap_req),
`ifdef BRIGHTNESS_EN
        .brightness(brightness),
`endif
        .swap_ack(swap_ack),
        .frame_start(frame_start),
        .col_out(col_out),
        .row_out(row_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < COLS; i++) begin
            front_m[i] = '0;
            back_m[i]  = '0;
        end
        pending_m = 1'b0;
        pos_m     = 0;
    endtask

    // One clock: predict the registered outputs from the model, advance the model, compare after the edge.
    task automatic step();
        int              sc;
        int              col;
        int              lim;
        bit              drive;
        bit              sw;
        logic [COLS-1:0] ec;
        logic [ROWS-1:0] er;
        logic            ef;
        sc  = pos_m % DIV;
        col = pos_m / DIV;
`ifdef BRIGHTNESS_EN
        lim = BLANK + int'(brightness);
`else
        lim = DIV;
`endif
        drive = enable && (sc >= BLANK) && (sc < lim);
        ec    = drive ? COLS'(1 << col) : '0;
        er    = drive ? ~front_m[col] : 7'h7f;
        ef    = enable && (pos_m == 0);
        sw    = (pending_m || swap_req) && (!enable || pos_m == FRAME - 1);
        if (sw) begin
            for (int i = 0; i < COLS; i++) front_m[i] = back_m[i];
        end
        if (wr_en && wr_col < 3'(COLS)) back_m[wr_col] = wr_data;
        pending_m = sw ? 1'b0 : (pending_m || swap_req);
        pos_m     = enable ? (pos_m + 1) % FRAME : 0;
        @(posedge clock);
        #1;
        chk("col_out", 32'(col_out), 32'(ec));
        chk("row_out", 32'(row_out), 32'(er));
        chk("frame_start", 32'(frame_start), 32'(ef));
        chk("swap_ack", 32'(swap_ack), 32'(sw));
        if (swap_ack) ack_seen++;
        if (frame_start) fs_cnt++;
        if (col_out != '0) act_cnt++;
    endtask

    task automatic run_to(input int p);
        int guard;
        guard = 0;
        while (pos_m != p && guard < 4 * FRAME) begin
            step();
            guard++;
        end
        if (pos_m != p) chk("run_to_timeout", 32'(pos_m), 32'(p));
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        ack_seen   = 0;
        fs_cnt     = 0;
        act_cnt    = 0;
        reset_n    = 1'b0;
        enable     = 1'b0;
        wr_en      = 1'b0;
        wr_col     = 3'd0;
        wr_data    = 7'd0;
        swap_req   = 1'b0;
        brightness = 8'd255;
        pat[0] = 7'b0000100;
        pat[1] = 7'b0001100;
        pat[2] = 7'b1000101;
        pat[3] = 7'b1110001;
        pat[4] = 7'b1000011;
        model_reset();

        // Reset state
        #12;
        chk("rst_col", 32'(col_out), 32'd0);
        chk("rst_row", 32'(row_out), 32'h7f);
        chk("rst_ack", 32'(swap_ack), 32'd0);
        chk("rst_fs", 32'(frame_start), 32'd0);
        #10 reset_n = 1'b1;

        // 1: scan order, blanking and frame period
        enable = 1'b1;
        fs_cnt = 0;
        act_cnt = 0;
        repeat (2 * FRAME) step();
        chk("fs_count", 32'(fs_cnt), 32'd2);
        chk("active_cycles", 32'(act_cnt), 32'd60);

        // 2: load back buffer, swap mid-frame, tear-free at frame end
        for (int c = 0; c < COLS; c++) begin
            wr_en = 1'b1; wr_col = 3'(c); wr_data = pat[c];
            step();
        end
        wr_col = 3'd6; wr_data = 7'($urandom);
        step();
        wr_en = 1'b0;
        run_to(17);
        swap_req = 1'b1;
        step();
        swap_req = 1'b0;
        ack_seen = 0;
        run_to(BLANK);
        step();
        chk("c0_rows", 32'(row_out), 32'(7'b1111011));
        chk("ack_once", 32'(ack_seen), 32'd1);
        run_to(2 * DIV + BLANK);
        step();
        chk("c2_rows", 32'(row_out), 32'(7'b0111010));

        // 3: held request plus write in the swap cycle
        old3 = pat[3];
        new3 = 7'($urandom);
        if (new3 == old3) new3 = ~old3;
        run_to(FRAME - 3);
        ack_seen = 0;
        swap_req = 1'b1;
        step();
        step();
        wr_en = 1'b1; wr_col = 3'd3; wr_data = new3;
        step();
        swap_req = 1'b0; wr_en = 1'b0;
        run_to(3 * DIV + BLANK);
        step();
        exp_rows = ~old3;
        chk("pre_write_front", 32'(row_out), 32'(exp_rows));
        chk("one_ack_held", 32'(ack_seen), 32'd1);
        swap_req = 1'b1;
        step();
        swap_req = 1'b0;
        run_to(3 * DIV + BLANK);
        step();
        exp_rows = ~new3;
        chk("post_write_front", 32'(row_out), 32'(exp_rows));

        // Random traffic against the model
        repeat (200) begin
            wr_en    = 1'($urandom_range(0, 1));
            wr_col   = 3'($urandom_range(0, 7));
            wr_data  = 7'($urandom);
            swap_req = ($urandom_range(0, 15) == 0);
            step();
        end
        wr_en = 1'b0; swap_req = 1'b0;

        // 4: disable mid-slot, swap while dark, restart at column 0
        run_to(DIV + 4);
        enable = 1'b0;
        step();
        chk("dis_col", 32'(col_out), 32'd0);
        chk("dis_row", 32'(row_out), 32'h7f);
        wr_en = 1'b1; wr_col = 3'd0; wr_data = 7'($urandom);
        step();
        wr_en = 1'b0;
        ack_seen = 0;
        swap_req = 1'b1;
        step();
        swap_req = 1'b0;
        chk("dis_swap_ack", 32'(ack_seen), 32'd1);
        step();
        enable = 1'b1;
        step();
        chk("restart_fs", 32'(frame_start), 32'd1);
        repeat (FRAME) step();

        // 5: asynchronous reset mid-frame with a pending swap
        run_to(13);
        swap_req = 1'b1;
        step();
        swap_req = 1'b0;
        step();
        step();
        #2 reset_n = 1'b0;
        #1;
        chk("arst_col", 32'(col_out), 32'd0);
        chk("arst_row", 32'(row_out), 32'h7f);
        chk("arst_ack", 32'(swap_ack), 32'd0);
        chk("arst_fs", 32'(frame_start), 32'd0);
        model_reset();
        #3 reset_n = 1'b1;
        ack_seen = 0;
        run_to(4 * DIV + BLANK);
        step();
        chk("front_cleared_col", 32'(col_out), 32'(5'b10000));
        chk("front_cleared_row", 32'(row_out), 32'h7f);
        repeat (FRAME) step();
        chk("no_ack_after_rst", 32'(ack_seen), 32'd0);

`ifdef BRIGHTNESS_EN
        // 6: brightness limits the drive window
        run_to(0);
        brightness = 8'd3;
        act_cnt = 0;
        repeat (FRAME) step();
        chk("bright3_active", 32'(act_cnt), 32'd15);
        brightness = 8'd0;
        act_cnt = 0;
        repeat (FRAME) step();
        chk("bright0_active", 32'(act_cnt), 32'd0);
        brightness = 8'd255;
        act_cnt = 0;
        repeat (FRAME) step();
        chk("bright255_active", 32'(act_cnt), 32'd30);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
